// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES inverse cipher, one round per clock, NK = 4/6/8
// Optional macro AES_DEC_KEYREG_EN: capture the whole rkeys vector on the accept edge.
module aes_inv_cipher_iter #(
   parameter int NK = 4
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [127:0]          data_in,
   input  logic [128*(NK+7)-1:0] rkeys,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [127:0]          data_out,
   output logic                  busy,
   output logic [3:0]            round_idx
);
   localparam int NR = NK + 6;
   localparam int KW = 128 * (NR + 1);
   localparam logic [3:0] LAST_MID = 4'(NR - 1);

   if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
      $error("aes_inv_cipher_iter: NK must be 4, 6 or 8");
   end

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    r_q, r_d;
   logic [127:0]  blk_q, blk_d;
   logic [127:0]  dout_q, dout_d;
   logic          alive_q;
   logic [KW-1:0] keys_src;
   logic [127:0]  rk_arr [16];
   logic [127:0]  isb_w, ark_w, imc_w;

`ifdef AES_DEC_KEYREG_EN
   logic [KW-1:0] key_q, key_d;
   assign keys_src = key_q;
`else
   assign keys_src = rkeys;
`endif

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Inverse affine map, then multiplicative inverse as x^254 (0 maps to 0).
   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      logic [7:0] x, sq, acc;
      x   = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      acc = 8'h01;
      sq  = x;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

   // Round-key mux indexed by r; unused slots are tied off so r indexes a full 16-entry table.
   for (genvar i = 0; i < 16; i++) begin : g_rk
      if (i <= NR) begin : g_used
         assign rk_arr[i] = keys_src[128*i +: 128];
      end else begin : g_unused
         assign rk_arr[i] = '0;
      end
   end

   assign isb_w = inv_sub_bytes(inv_shift_rows(blk_q));
   assign ark_w = isb_w ^ rk_arr[r_q];
   assign imc_w = inv_mix_columns(ark_w);

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      blk_d   = blk_q;
      dout_d  = dout_q;
`ifdef AES_DEC_KEYREG_EN
      key_d   = key_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               blk_d   = data_in ^ rkeys[127:0];
               r_d     = 4'd1;
               state_d = S_ROUND;
`ifdef AES_DEC_KEYREG_EN
               key_d   = rkeys;
`endif
            end
         end
         S_ROUND: begin
            blk_d = imc_w;
            r_d   = r_q + 4'd1;
            if (r_q == LAST_MID) state_d = S_FINAL;
         end
         S_FINAL: begin
            dout_d  = ark_w;
            r_d     = 4'd0;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         blk_q   <= '0;
         dout_q  <= '0;
         alive_q <= 1'b0;
`ifdef AES_DEC_KEYREG_EN
         key_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         blk_q   <= blk_d;
         dout_q  <= dout_d;
         alive_q <= 1'b1;
`ifdef AES_DEC_KEYREG_EN
         key_q   <= key_d;
`endif
      end
   end

   // alive_q keeps in_ready low until the first edge after reset release.
   assign in_ready  = (state_q == S_IDLE) && alive_q;
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_ROUND) || (state_q == S_FINAL);
   assign data_out  = dout_q;
   assign round_idx = r_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb/tb_aes_inv_cipher_iter.sv - directed bench for aes_inv_cipher_iter at NK = 4, 6 and 8
`timescale 1ns/1ps
module tb_aes_inv_cipher_iter;
   localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] RK10_128 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] KEY128   = 128'h000102030405060708090a0b0c0d0e0f;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic iv[3], ord[3], ir[3], ov[3], bz[3];
   logic [127:0] din[3], dout[3];
   logic [3:0] ridx[3];
   logic [128*15-1:0] rk[3];
   logic [7:0] sb[256], isb[256];
   int n_chk = 0;
   int n_err = 0;

   int m_st[3], m_cnt[3];
   bit m_alive[3];
   logic [127:0] m_out[3], m_ct[3];
   logic [128*15-1:0] m_key[3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int NKG = 4 + 2 * g;
      aes_inv_cipher_iter #(.NK(NKG)) u_dut (
         .CLK(clk), .RST_N(rst_n),
         .in_valid(iv[g]), .in_ready(ir[g]), .data_in(din[g]),
         .rkeys(rk[g][128*(NKG+7)-1:0]),
         .out_valid(ov[g]), .out_ready(ord[g]), .data_out(dout[g]),
         .busy(bz[g]), .round_idx(ridx[g])
      );
   end

   task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d got %h want %h", nm, d, act, exp);
      end
   endtask

   function automatic int nr_of(input int d);
      return 10 + 2 * d;
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
      for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0)
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
         sb[x]  = s;
         isb[s] = 8'(x);
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
   endfunction

   // Encryption schedule for key bytes 00,01,02,..., stored in reverse round order.
   task automatic build_rkeys(input int nk, output logic [128*15-1:0] v);
      logic [31:0] w[60];
      logic [31:0] t;
      logic [7:0]  rc;
      int nr;
      nr = nk + 6;
      rc = 8'h01;
      v  = '0;
      for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r <= nr; r++)
         v[128*r +: 128] = {w[4*(nr-r)], w[4*(nr-r)+1], w[4*(nr-r)+2], w[4*(nr-r)+3]};
   endtask

   function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [128*15-1:0] keys, input int nr);
      logic [7:0] m[4][4];
      logic [7:0] n[4][4];
      logic [7:0] base[4];
      logic [7:0] acc;
      logic [127:0] k, o;
      base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            m[r][c] = ct[127-8*(4*c+r) -: 8] ^ keys[127-8*(4*c+r) -: 8];
      for (int rnd = 1; rnd <= nr; rnd++) begin
         k = keys[128*rnd +: 128];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               n[r][c] = isb[m[r][(c-r+4)%4]] ^ k[127-8*(4*c+r) -: 8];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
               acc = n[r][c];
               if (rnd < nr) begin
                  acc = 8'h00;
                  for (int j = 0; j < 4; j++) acc = acc ^ gmul(base[(j-r+4)%4], n[j][c]);
               end
               m[r][c] = acc;
            end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = m[r][c];
      return o;
   endfunction

   function automatic logic [128*15-1:0] rnd_keys();
      logic [128*15-1:0] v;
      for (int i = 0; i < 60; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   // Transaction-level expectation: idle / busy for NR cycles / done until out_ready.
   always @(posedge clk or negedge rst_n) begin
      for (int d = 0; d < 3; d++) begin
         if (!rst_n) begin
            m_st[d] = 0; m_cnt[d] = 0; m_alive[d] = 1'b0; m_out[d] = '0;
         end else begin
            case (m_st[d])
               0: if (iv[d] && m_alive[d]) begin
                     m_st[d] = 1; m_cnt[d] = 1; m_ct[d] = din[d]; m_key[d] = rk[d];
                  end
               1: if (m_cnt[d] == nr_of(d)) begin
                     m_st[d] = 2; m_cnt[d] = 0;
                     m_out[d] = model_dec(m_ct[d], m_key[d], nr_of(d));
                  end else begin
                     m_cnt[d]++;
                  end
               default: if (ord[d]) m_st[d] = 0;
            endcase
            m_alive[d] = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         chk("in_ready",  d, 128'(ir[d]), 128'((m_st[d] == 0) && m_alive[d]));
         chk("out_valid", d, 128'(ov[d]), 128'(m_st[d] == 2));
         chk("busy",      d, 128'(bz[d]), 128'(m_st[d] == 1));
         chk("round_idx", d, 128'(ridx[d]), (m_st[d] == 1) ? 128'(m_cnt[d]) : 128'd0);
         chk("data_out",  d, dout[d], m_out[d]);
`ifndef AES_DEC_KEYREG_EN
         if (rst_n && bz[d]) chk("rkeys_stable", d, 128'(rk[d] == m_key[d]), 128'd1);
`endif
      end
   end

   task automatic accept(input int d, input logic [127:0] ct);
      int n;
      n = 0;
      while (!ir[d] && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("accept_wait", d, 128'(ir[d]), 128'd1);
      din[d] = ct;
      iv[d]  = 1'b1;
      @(posedge clk); #1;
      iv[d]  = 1'b0;
      din[d] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic finish(input int d, input logic [127:0] pt, input int lat, input int hold,
                         input bit scram, input bit iv_rel, input logic [127:0] ct_rel);
      int n;
      logic [128*15-1:0] saved;
      saved = rk[d];
      n = 0;
      while (!ov[d] && n < 40) begin
         if (scram) rk[d] = rnd_keys();
         @(posedge clk); #1; n++;
      end
      rk[d] = saved;
      chk("latency",   d, 128'(n), 128'(lat));
      chk("plaintext", d, dout[d], pt);
      for (int i = 0; i < hold; i++) begin
         rk[d] = rnd_keys();
         @(posedge clk); #1;
         chk("hold_valid",   d, 128'(ov[d]), 128'd1);
         chk("hold_data",    d, dout[d], pt);
         chk("hold_inready", d, 128'(ir[d]), 128'd0);
      end
      rk[d]  = saved;
      ord[d] = 1'b1;
      if (iv_rel) begin
         iv[d]  = 1'b1;
         din[d] = ct_rel;
      end
      @(posedge clk); #1;
      ord[d] = 1'b0;
      chk("release_idle", d, 128'(ir[d]), 128'd1);
      chk("release_busy", d, 128'(bz[d]), 128'd0);
      chk("release_ov",   d, 128'(ov[d]), 128'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n;
      bit seen;
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b0; ord[d] = 1'b0; din[d] = '0;
      end
      build_sbox();
      chk("sbox_00", 0, 128'(sb[8'h00]), 128'h63);
      chk("sbox_01", 0, 128'(sb[8'h01]), 128'h7c);
      chk("sbox_53", 0, 128'(sb[8'h53]), 128'hed);
      chk("isbox_00", 0, 128'(isb[8'h00]), 128'h52);
      for (int d = 0; d < 3; d++) build_rkeys(4 + 2 * d, rk[d]);
      chk("rk_slot0", 0, rk[0][127:0], RK10_128);
      chk("rk_slot10", 0, rk[0][128*10 +: 128], KEY128);
      chk("model_c1", 0, model_dec(CT1, rk[0], 10), PT);
      chk("model_c2", 1, model_dec(CT2, rk[1], 12), PT);
      chk("model_c3", 2, model_dec(CT3, rk[2], 14), PT);

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) chk("ready_before_edge", d, 128'(ir[d]), 128'd0);
      @(posedge clk); #1;
      chk("ready_after_edge", 0, 128'(ir[0]), 128'd1);

      accept(0, CT1); finish(0, PT, 10, 2, 1'b0, 1'b0, '0);
      accept(1, CT2); finish(1, PT, 12, 2, 1'b0, 1'b0, '0);
      accept(2, CT3); finish(2, PT, 14, 2, 1'b0, 1'b0, '0);

      // Back-pressure, then release together with a new in_valid: only DONE->IDLE on that edge.
      accept(0, CT1);
      finish(0, PT, 10, 20, 1'b0, 1'b1, CT1);
      @(posedge clk); #1;
      iv[0] = 1'b0;
      chk("accept_after_release", 0, 128'(bz[0]), 128'd1);
      finish(0, PT, 10, 0, 1'b0, 1'b0, '0);

      // Throughput with in_valid and out_ready held high.
      din[0] = CT1; iv[0] = 1'b1; ord[0] = 1'b1;
      @(posedge clk); #1;
      chk("tput_first_accept", 0, 128'(bz[0]), 128'd1);
      n = 0; seen = 1'b0;
      while (n < 40) begin
         @(posedge clk); #1; n++;
         if (!bz[0]) seen = 1'b1;
         else if (seen) break;
      end
      chk("throughput", 0, 128'(n), 128'd12);
      iv[0] = 1'b0; ord[0] = 1'b0;
      finish(0, PT, 10, 0, 1'b0, 1'b0, '0);

      // Asynchronous reset in the middle of a block.
      accept(0, CT1);
      n = 0;
      while (ridx[0] != 4'd5 && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("reach_round5", 0, 128'(ridx[0]), 128'd5);
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", 0, 128'(ov[0]), 128'd0);
      chk("rst_busy",      0, 128'(bz[0]), 128'd0);
      chk("rst_data_out",  0, dout[0], 128'd0);
      chk("rst_round_idx", 0, 128'(ridx[0]), 128'd0);
      chk("rst_in_ready",  0, 128'(ir[0]), 128'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("ready_before_edge2", 0, 128'(ir[0]), 128'd0);
      @(posedge clk); #1;
      accept(0, CT1); finish(0, PT, 10, 2, 1'b0, 1'b0, '0);

`ifdef AES_DEC_KEYREG_EN
      accept(0, CT1); finish(0, PT, 10, 2, 1'b1, 1'b0, '0);
`endif

      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
